// File: rtl/call_request_scheduler.sv
// Request stage of the elevator controller: synchronises and debounces the
// hall-call and car-target buttons, keeps them pending until serviced, runs the
// collective up/down direction FSM and registers a one-hot next-target floor.
module call_request_scheduler #(
    parameter int DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic [3:0] hall_up,
    input  logic [3:0] hall_dn,
    input  logic [4:0] car_tgt,
    input  logic [4:0] floor_oh,
    input  logic       stop,
    input  logic       door_open,
    output logic [4:0] next_floor,
    output logic       tgt_valid,
    output logic [1:0] dir,
    output logic [3:0] up_pend,
    output logic [3:0] dn_pend,
    output logic [4:0] car_pend
);

    localparam int NB = 13;
    localparam logic [3:0] DEB_MAX = 4'(DEB_CYCLES);
    localparam logic [3:0] DEB_M1  = 4'(DEB_CYCLES - 1);

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    // Lowest set bit of a floor vector (nearest floor when scanning upward).
    function automatic logic [4:0] lowest_bit(input logic [4:0] v);
        logic seen;
        lowest_bit = 5'd0;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            lowest_bit[k] = v[k] & ~seen;
            seen = seen | v[k];
        end
    endfunction

    // Highest set bit of a floor vector (nearest floor when scanning downward).
    function automatic logic [4:0] highest_bit(input logic [4:0] v);
        logic seen;
        highest_bit = 5'd0;
        seen = 1'b0;
        for (int k = 4; k >= 0; k--) begin
            highest_bit[k] = v[k] & ~seen;
            seen = seen | v[k];
        end
    endfunction

    // True when exactly one sensor bit is set.
    function automatic logic is_onehot5(input logic [4:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int k = 0; k < 5; k++) begin
            n = n + {2'b00, v[k]};
        end
        return (n == 3'd1);
    endfunction

    // Button vector layout: [3:0] hall up, [7:4] hall down, [12:8] car targets.
    logic [NB-1:0] btn_raw_s;
    logic [NB-1:0] sync1_q, sync2_q;
    logic [3:0]    cnt_q [NB];
    logic [3:0]    cnt_d [NB];
    logic [NB-1:0] press_s;

    logic [3:0] up_pend_q, up_pend_d;
    logic [3:0] dn_pend_q, dn_pend_d;
    logic [4:0] car_pend_q, car_pend_d;
    logic [4:0] cur_floor_q, cur_floor_d;
    logic [1:0] dir_q, dir_d;
    logic [4:0] next_floor_q, next_floor_d;
    logic       tgt_valid_q, tgt_valid_d;

    logic       svc_s, cur_valid_s;
    logic [4:0] clr_car_s;
    logic [3:0] clr_up_s, clr_dn_s;
    logic [4:0] up5_s, dn5_s, any_s, cu_s, cd_s;
    logic [4:0] above_m_s, below_m_s;
    logic       here_s, above_s, below_s;
    logic [4:0] up_tgt_s, dn_tgt_s;

    assign btn_raw_s = {car_tgt, hall_dn, hall_up};

    // Per-button debounce counter; a press is accepted on the cycle the count reaches DEB_CYCLES.
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            if (!sync2_q[i]) begin
                cnt_d[i] = 4'd0;
            end else if (cnt_q[i] == DEB_MAX) begin
                cnt_d[i] = cnt_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 4'd1;
            end
            press_s[i] = sync2_q[i] & (cnt_q[i] == DEB_M1);
        end
    end

    // Service clears at the current floor and pending-request update (clear beats set).
    always_comb begin
        svc_s     = stop & door_open;
        clr_car_s = svc_s ? cur_floor_q : 5'd0;
        clr_up_s  = svc_s ? (cur_floor_q[3:0] & ((dir_q == DIR_DOWN) ? 4'b0001 : 4'b1111)) : 4'd0;
        clr_dn_s  = svc_s ? (cur_floor_q[4:1] & ((dir_q == DIR_UP) ? 4'b1000 : 4'b1111)) : 4'd0;
        up_pend_d  = (up_pend_q  | press_s[3:0])  & ~clr_up_s;
        dn_pend_d  = (dn_pend_q  | press_s[7:4])  & ~clr_dn_s;
        car_pend_d = (car_pend_q | press_s[12:8]) & ~clr_car_s;
        cur_floor_d = is_onehot5(floor_oh) ? floor_oh : cur_floor_q;
    end

    // Per-floor request views and above/below masks relative to the current floor.
    always_comb begin
        logic seen_up, seen_dn;
        up5_s = {1'b0, up_pend_q};
        dn5_s = {dn_pend_q, 1'b0};
        any_s = car_pend_q | up5_s | dn5_s;
        cu_s  = car_pend_q | up5_s;
        cd_s  = car_pend_q | dn5_s;
        seen_up = 1'b0;
        for (int k = 0; k < 5; k++) begin
            above_m_s[k] = seen_up;
            seen_up = seen_up | cur_floor_q[k];
        end
        seen_dn = 1'b0;
        for (int k = 4; k >= 0; k--) begin
            below_m_s[k] = seen_dn;
            seen_dn = seen_dn | cur_floor_q[k];
        end
        cur_valid_s = |cur_floor_q;
        here_s  = |(any_s & cur_floor_q);
        above_s = |(any_s & above_m_s);
        below_s = |(any_s & below_m_s);
        up_tgt_s = (|(cu_s & above_m_s)) ? lowest_bit(cu_s & above_m_s)
                                         : highest_bit(dn5_s & above_m_s);
        dn_tgt_s = (|(cd_s & below_m_s)) ? highest_bit(cd_s & below_m_s)
                                         : lowest_bit(up5_s & below_m_s);
    end

    // Collective direction FSM; direction may only change while the car is stopped.
    always_comb begin
        dir_d = dir_q;
        if (stop && cur_valid_s) begin
            case (dir_q)
                DIR_IDLE: begin
                    if (here_s)       dir_d = DIR_IDLE;
                    else if (above_s) dir_d = DIR_UP;
                    else if (below_s) dir_d = DIR_DOWN;
                    else              dir_d = DIR_IDLE;
                end
                DIR_UP: begin
                    if (above_s)      dir_d = DIR_UP;
                    else if (below_s) dir_d = DIR_DOWN;
                    else              dir_d = DIR_IDLE;
                end
                DIR_DOWN: begin
                    if (below_s)      dir_d = DIR_DOWN;
                    else if (above_s) dir_d = DIR_UP;
                    else              dir_d = DIR_IDLE;
                end
                default: dir_d = DIR_IDLE;
            endcase
        end else begin
            dir_d = dir_q;
        end
    end

    // Next-target selection from the registered state.
    always_comb begin
        next_floor_d = 5'd0;
        if (!cur_valid_s) begin
            next_floor_d = 5'd0;
        end else begin
            case (dir_q)
                DIR_IDLE: begin
                    if (here_s)       next_floor_d = cur_floor_q;
                    else if (above_s) next_floor_d = up_tgt_s;
                    else if (below_s) next_floor_d = dn_tgt_s;
                    else              next_floor_d = 5'd0;
                end
                DIR_UP:   next_floor_d = up_tgt_s;
                DIR_DOWN: next_floor_d = dn_tgt_s;
                default:  next_floor_d = 5'd0;
            endcase
        end
        tgt_valid_d = |next_floor_d;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (RESET) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            for (int i = 0; i < NB; i++) cnt_q[i] <= 4'd0;
            up_pend_q    <= 4'd0;
            dn_pend_q    <= 4'd0;
            car_pend_q   <= 5'd0;
            cur_floor_q  <= 5'd0;
            dir_q        <= DIR_IDLE;
            next_floor_q <= 5'd0;
            tgt_valid_q  <= 1'b0;
        end else begin
            sync1_q      <= btn_raw_s;
            sync2_q      <= sync1_q;
            for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
            up_pend_q    <= up_pend_d;
            dn_pend_q    <= dn_pend_d;
            car_pend_q   <= car_pend_d;
            cur_floor_q  <= cur_floor_d;
            dir_q        <= dir_d;
            next_floor_q <= next_floor_d;
            tgt_valid_q  <= tgt_valid_d;
        end
    end

    assign next_floor = next_floor_q;
    assign tgt_valid  = tgt_valid_q;
    assign dir        = dir_q;
    assign up_pend    = up_pend_q;
    assign dn_pend    = dn_pend_q;
    assign car_pend   = car_pend_q;

endmodule

// File: tb/tb_call_request_scheduler.sv
// Self-checking bench for call_request_scheduler: directed scenarios followed by
// randomized traffic, compared each cycle against a floor-level reference model.
module tb_call_request_scheduler;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       RESET;
    logic [3:0] hall_up, hall_dn;
    logic [4:0] car_tgt, floor_oh;
    logic       stop, door_open;
    logic [4:0] next_floor;
    logic       tgt_valid;
    logic [1:0] dir;
    logic [3:0] up_pend, dn_pend;
    logic [4:0] car_pend;

    int tests = 0;
    int fails = 0;

    // Reference model state: floors numbered 1..5, bit f of each vector = floor f.
    int         m_cur, m_dir, m_nf;
    bit [5:0]   m_car, m_up, m_dn;
    logic [12:0] h [1:D+2];

    call_request_scheduler #(.DEB_CYCLES(D)) dut (
        .clk(clk), .RESET(RESET), .hall_up(hall_up), .hall_dn(hall_dn),
        .car_tgt(car_tgt), .floor_oh(floor_oh), .stop(stop), .door_open(door_open),
        .next_floor(next_floor), .tgt_valid(tgt_valid), .dir(dir),
        .up_pend(up_pend), .dn_pend(dn_pend), .car_pend(car_pend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit pend_at(int f);
        return m_car[f] | m_up[f] | m_dn[f];
    endfunction

    function automatic int tgt_up();
        for (int f = m_cur + 1; f <= 5; f++) if (m_car[f] | m_up[f]) return f;
        for (int f = 5; f > m_cur; f--) if (m_dn[f]) return f;
        return 0;
    endfunction

    function automatic int tgt_dn();
        for (int f = m_cur - 1; f >= 1; f--) if (m_car[f] | m_dn[f]) return f;
        for (int f = 1; f < m_cur; f++) if (m_up[f]) return f;
        return 0;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        logic [12:0] raw, acc;
        bit here, above, below, svc;
        int nd, nt, ones, idx;
        if (RESET) begin
            m_cur = 0; m_dir = 0; m_nf = 0;
            m_car = '0; m_up = '0; m_dn = '0;
            for (int j = 1; j <= D + 2; j++) h[j] = '0;
        end else begin
            raw = {car_tgt, hall_dn, hall_up};
            // accepted on the D-th consecutive high sample, two samples back
            acc = '1;
            for (int j = 2; j <= D + 1; j++) acc = acc & h[j];
            acc = acc & ~h[D+2];
            here = 0; above = 0; below = 0;
            if (m_cur != 0) begin
                here = pend_at(m_cur);
                for (int f = 1; f <= 5; f++) begin
                    if (f > m_cur && pend_at(f)) above = 1;
                    if (f < m_cur && pend_at(f)) below = 1;
                end
            end
            nd = m_dir;
            if (stop && m_cur != 0) begin
                if (m_dir == 0)      nd = here ? 0 : above ? 1 : below ? 2 : 0;
                else if (m_dir == 1) nd = above ? 1 : below ? 2 : 0;
                else                 nd = below ? 2 : above ? 1 : 0;
            end
            nt = 0;
            if (m_cur != 0) begin
                if (m_dir == 1)      nt = tgt_up();
                else if (m_dir == 2) nt = tgt_dn();
                else                 nt = here ? m_cur : above ? tgt_up() : below ? tgt_dn() : 0;
            end
            svc = stop && door_open && m_cur != 0;
            for (int f = 1; f <= 5; f++) begin
                m_car[f] = m_car[f] | acc[8 + f - 1];
                if (f <= 4) m_up[f] = m_up[f] | acc[f - 1];
                if (f >= 2) m_dn[f] = m_dn[f] | acc[4 + f - 2];
            end
            if (svc) begin
                m_car[m_cur] = 0;
                if (m_dir != 2 || m_cur == 1) m_up[m_cur] = 0;
                if (m_dir != 1 || m_cur == 5) m_dn[m_cur] = 0;
            end
            m_dir = nd;
            m_nf = nt;
            ones = 0; idx = 0;
            for (int f = 1; f <= 5; f++) if (floor_oh[f-1]) begin ones++; idx = f; end
            if (ones == 1) m_cur = idx;
            for (int j = D + 2; j >= 2; j--) h[j] = h[j-1];
            h[1] = raw;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all();
        logic [4:0] enf;
        enf = (m_nf == 0) ? 5'd0 : 5'(5'd1 << (m_nf - 1));
        chk("next_floor", 32'(next_floor), 32'(enf));
        chk("tgt_valid", 32'(tgt_valid), 32'(m_nf != 0));
        chk("dir", 32'(dir), 32'(m_dir));
        chk("up_pend", 32'(up_pend), 32'(m_up[4:1]));
        chk("dn_pend", 32'(dn_pend), 32'(m_dn[5:2]));
        chk("car_pend", 32'(car_pend), 32'(m_car[5:1]));
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; hall_up = '0; hall_dn = '0; car_tgt = '0;
        floor_oh = '0; stop = 1'b0; door_open = 1'b0;
        @(negedge clk);
        do_reset();
        chk("reset_car", 32'(car_pend), 32'd0);
        chk("reset_dir", 32'(dir), 32'd0);
        check_all();

        // short press is rejected, long press accepted after DEB+2 cycles
        car_tgt = 5'b00100;
        repeat (3) begin tick(); check_all(); end
        car_tgt = 5'b00000;
        repeat (4) begin tick(); check_all(); end
        chk("short_press", 32'(car_pend), 32'd0);
        car_tgt = 5'b00100;
        repeat (5) begin tick(); check_all(); end
        chk("long_press_early", 32'(car_pend), 32'd0);
        tick(); check_all();
        chk("long_press", 32'(car_pend), 32'h04);
        car_tgt = 5'b00000;

        // car at floor 1 gets a floor-5 request -> heads UP to floor 5
        do_reset();
        floor_oh = 5'b00001; stop = 1'b1;
        car_tgt = 5'b10000;
        repeat (6) begin tick(); check_all(); end
        car_tgt = 5'b00000;
        chk("up_pend_set", 32'(car_pend), 32'h10);
        chk("up_dir_before", 32'(dir), 32'd0);
        tick(); check_all();
        chk("up_dir", 32'(dir), 32'd1);
        chk("up_target", 32'(next_floor), 32'h10);

        // button held at the open-door floor is absorbed, then re-press sets
        do_reset();
        floor_oh = 5'b00100; stop = 1'b1; door_open = 1'b1;
        car_tgt = 5'b00100;
        repeat (10) begin tick(); check_all(); end
        chk("absorbed", 32'(car_pend), 32'd0);
        car_tgt = 5'b00000; door_open = 1'b0;
        repeat (2) begin tick(); check_all(); end
        car_tgt = 5'b00100;
        repeat (D + 2) begin tick(); check_all(); end
        chk("repress", 32'(car_pend), 32'h04);
        car_tgt = 5'b00000;

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            hall_up  = hall_up ^ 4'(($urandom_range(7) == 0) ? $urandom_range(15) : 0);
            hall_dn  = hall_dn ^ 4'(($urandom_range(7) == 0) ? $urandom_range(15) : 0);
            car_tgt  = car_tgt ^ 5'(($urandom_range(7) == 0) ? $urandom_range(31) : 0);
            if ($urandom_range(3) == 0) begin
                case ($urandom_range(9))
                    0:       floor_oh = 5'd0;
                    1:       floor_oh = 5'($urandom_range(31));
                    default: floor_oh = 5'(5'd1 << $urandom_range(4));
                endcase
            end
            if ($urandom_range(3) == 0) stop = ~stop;
            if ($urandom_range(2) == 0) door_open = ~door_open;
            RESET = ($urandom_range(499) == 0);
            tick();
            check_all();
        end
        RESET = 1'b0;

        // reset in the middle of activity clears everything on the next edge
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("mid_reset_up", 32'(up_pend), 32'd0);
        chk("mid_reset_dn", 32'(dn_pend), 32'd0);
        chk("mid_reset_car", 32'(car_pend), 32'd0);
        chk("mid_reset_dir", 32'(dir), 32'd0);
        chk("mid_reset_nf", 32'(next_floor), 32'd0);
        chk("mid_reset_tv", 32'(tgt_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
